// File: rtl/audio_pkt_pkg.sv
// Shared types and helpers for the audio UDP packer: send FSM states, header size and
// big-endian byte slicing of samples.
package audio_pkt_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HDR,
        ST_PAYLOAD,
        ST_DONE
    } send_state_t;

    localparam int HDR_LEN = 4;

    // Lane 0 is the most significant byte of an sw-bit sample held right-aligned in smp.
    function automatic logic [7:0] be_byte(input logic [31:0] smp, input int sw, input int lane);
        logic [31:0] sh;
        sh = smp >> (sw - 8 * (lane + 1));
        return sh[7:0];
    endfunction

endpackage

// File: rtl/audio_pkt_bank.sv
// Ping-pong sample store: two banks of 2**AW samples in one simple dual-port RAM, bank
// select as the address MSB, with a single write port and a registered read port.
module audio_pkt_bank #(
    parameter int SW = 16,
    parameter int AW = 7
) (
    input  logic          clk,
    input  logic          we,
    input  logic          wr_bank,
    input  logic [AW-1:0] waddr,
    input  logic [SW-1:0] wdata,
    input  logic          rd_bank,
    input  logic [AW-1:0] raddr,
    output logic [SW-1:0] rdata
);

    logic [SW-1:0] mem [0:(2 ** (AW + 1)) - 1];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[{wr_bank, waddr}] <= wdata;
        end
        rdata <= mem[{rd_bank, raddr}];
    end

endmodule

// File: rtl/audio_udp_packer.sv
// Gathers one sample per channel per frame into a ping-pong store and streams each full bank as a
// byte-serial UDP payload. Define AUDIO_PKT_HDR_EN to prepend a 4-byte seq/CH/SW header.
module audio_udp_packer #(
    parameter int CH     = 2,
    parameter int SW     = 16,
    parameter int FRAMES = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [CH-1:0]    smp_valid,
    input  logic [CH*SW-1:0] smp_data,
    output logic             udp_send_data_valid,
    input  logic             udp_send_data_ready,
    output logic [7:0]       udp_send_data,
    output logic [15:0]      udp_send_data_length,
    output logic [15:0]      pkt_seq,
    output logic [15:0]      drop_cnt
);
    import audio_pkt_pkg::*;

    localparam int NS  = FRAMES * CH;
    localparam int BPS = SW / 8;
    localparam int AW  = $clog2(NS);
    localparam int FW  = $clog2(FRAMES);
    localparam int CW  = (CH > 1) ? $clog2(CH) : 1;
    localparam int LW  = (BPS > 1) ? $clog2(BPS) : 1;
`ifdef AUDIO_PKT_HDR_EN
    localparam bit HDR_ON = 1'b1;
`else
    localparam bit HDR_ON = 1'b0;
`endif
    localparam int PKT_LEN = NS * BPS + (HDR_ON ? HDR_LEN : 0);

    send_state_t   state;
    logic [SW-1:0] stage   [CH];
    logic [SW-1:0] cmt_buf [CH];
    logic [CH-1:0] pending;
    logic [CH-1:0] pend_nxt;
    logic          cmt_go;
    logic          cmt_busy;
    logic [CW-1:0] cmt_ch;
    logic [FW-1:0] wr_idx;
    logic          wr_bank;
    logic          wr_ok;
    logic [1:0]    full;
    logic          rd_bank;
    logic [AW-1:0] wr_addr;
    logic [AW-1:0] rd_addr;
    logic [SW-1:0] rd_data;
    logic [SW-1:0] smp;
    logic [AW-1:0] smp_idx;
    logic [LW-1:0] lane;

    assign pend_nxt = pending | smp_valid;
    assign wr_addr  = AW'(int'(wr_idx) * CH + int'(cmt_ch));
    // The read side always looks one sample ahead, so the next sample is waiting in rd_data.
    assign rd_addr  = (state == ST_PAYLOAD) ? smp_idx + AW'(1) : '0;
    assign wr_ok    = !full[wr_bank] || (state == ST_DONE && rd_bank == wr_bank);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pending <= '0;
            cmt_go  <= 1'b0;
        end else begin
            cmt_go  <= &pend_nxt;
            pending <= (&pend_nxt) ? '0 : pend_nxt;
        end
        for (int k = 0; k < CH; k++) begin
            if (smp_valid[k]) begin
                stage[k] <= smp_data[k*SW +: SW];
            end
        end
    end

    // A completed frame is snapshotted and written one channel per cycle, or counted as dropped.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cmt_busy <= 1'b0;
            cmt_ch   <= '0;
            wr_idx   <= '0;
            wr_bank  <= 1'b0;
            full     <= 2'b00;
            drop_cnt <= '0;
        end else begin
            if (state == ST_DONE) begin
                full[rd_bank] <= 1'b0;
            end
            if (cmt_busy) begin
                if (cmt_ch == CW'(CH - 1)) begin
                    cmt_busy <= 1'b0;
                    if (wr_idx == FW'(FRAMES - 1)) begin
                        full[wr_bank] <= 1'b1;
                        wr_bank       <= ~wr_bank;
                        wr_idx        <= '0;
                    end else begin
                        wr_idx <= wr_idx + FW'(1);
                    end
                end else begin
                    cmt_ch <= cmt_ch + CW'(1);
                end
            end
            if (cmt_go) begin
                if (wr_ok) begin
                    cmt_busy <= 1'b1;
                    cmt_ch   <= '0;
                    for (int k = 0; k < CH; k++) begin
                        cmt_buf[k] <= stage[k];
                    end
                end else if (drop_cnt != 16'hFFFF) begin
                    drop_cnt <= drop_cnt + 16'd1;
                end
            end
        end
    end

    audio_pkt_bank #(
        .SW(SW),
        .AW(AW)
    ) u_bank (
        .clk    (clk),
        .we     (cmt_busy),
        .wr_bank(wr_bank),
        .waddr  (wr_addr),
        .wdata  (cmt_buf[cmt_ch]),
        .rd_bank(rd_bank),
        .raddr  (rd_addr),
        .rdata  (rd_data)
    );

`ifdef AUDIO_PKT_HDR_EN
    logic [1:0]  hdr_idx;
    logic [15:0] seq_n;

    assign seq_n = pkt_seq + 16'd1;

    function automatic logic [7:0] hdr_byte(input logic [1:0] idx, input logic [15:0] seq);
        case (idx)
            2'd0:    return seq[15:8];
            2'd1:    return seq[7:0];
            2'd2:    return 8'(CH);
            default: return 8'(SW);
        endcase
    endfunction
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state                <= ST_IDLE;
            udp_send_data_valid  <= 1'b0;
            udp_send_data        <= '0;
            udp_send_data_length <= '0;
            pkt_seq              <= '0;
            rd_bank              <= 1'b0;
            smp                  <= '0;
            smp_idx              <= '0;
            lane                 <= '0;
`ifdef AUDIO_PKT_HDR_EN
            hdr_idx              <= '0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    udp_send_data_valid <= 1'b0;
                    if (full[rd_bank]) begin
                        smp_idx              <= '0;
                        lane                 <= '0;
                        udp_send_data_length <= 16'(PKT_LEN);
`ifdef AUDIO_PKT_HDR_EN
                        hdr_idx              <= '0;
                        state                <= ST_HDR;
`else
                        state                <= ST_PAYLOAD;
`endif
                    end
                end
`ifdef AUDIO_PKT_HDR_EN
                ST_HDR: begin
                    if (!udp_send_data_valid) begin
                        udp_send_data_valid <= 1'b1;
                        udp_send_data       <= hdr_byte(2'd0, seq_n);
                    end else if (udp_send_data_ready) begin
                        if (hdr_idx == 2'(HDR_LEN - 1)) begin
                            state         <= ST_PAYLOAD;
                            smp           <= rd_data;
                            udp_send_data <= be_byte(32'(rd_data), SW, 0);
                            lane          <= '0;
                        end else begin
                            hdr_idx       <= hdr_idx + 2'd1;
                            udp_send_data <= hdr_byte(hdr_idx + 2'd1, seq_n);
                        end
                    end
                end
`endif
                ST_PAYLOAD: begin
                    if (!udp_send_data_valid) begin
                        udp_send_data_valid <= 1'b1;
                        smp                 <= rd_data;
                        udp_send_data       <= be_byte(32'(rd_data), SW, 0);
                        lane                <= '0;
                    end else if (udp_send_data_ready) begin
                        if (lane == LW'(BPS - 1)) begin
                            if (smp_idx == AW'(NS - 1)) begin
                                state               <= ST_DONE;
                                udp_send_data_valid <= 1'b0;
                            end else begin
                                smp_idx       <= smp_idx + AW'(1);
                                smp           <= rd_data;
                                udp_send_data <= be_byte(32'(rd_data), SW, 0);
                                lane          <= '0;
                            end
                        end else begin
                            lane          <= lane + LW'(1);
                            udp_send_data <= be_byte(32'(smp), SW, int'(lane) + 1);
                        end
                    end
                end
                ST_DONE: begin
                    udp_send_data_valid <= 1'b0;
                    pkt_seq             <= pkt_seq + 16'd1;
                    rd_bank             <= ~rd_bank;
                    state               <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_audio_udp_packer.sv
// Scoreboard bench for audio_udp_packer (CH=2, SW=16, FRAMES=4): stimulus pushes expected bytes,
// a negedge monitor pops and compares every accepted byte. Honours AUDIO_PKT_HDR_EN.
module tb_audio_udp_packer;

    localparam int CH     = 2;
    localparam int SW     = 16;
    localparam int FRAMES = 4;
`ifdef AUDIO_PKT_HDR_EN
    localparam bit HDR = 1'b1;
    localparam int LEN = 20;
`else
    localparam bit HDR = 1'b0;
    localparam int LEN = 16;
`endif

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [CH-1:0]    smp_valid = '0;
    logic [CH*SW-1:0] smp_data = '0;
    logic             ready = 1'b0;
    logic             valid;
    logic [7:0]       data;
    logic [15:0]      length;
    logic [15:0]      pkt_seq;
    logic [15:0]      drop_cnt;

    logic [7:0] exp_q[$];
    int         checks = 0;
    int         errors = 0;
    int         blk_cnt = 0;

    audio_udp_packer #(
        .CH    (CH),
        .SW    (SW),
        .FRAMES(FRAMES)
    ) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .smp_valid           (smp_valid),
        .smp_data            (smp_data),
        .udp_send_data_valid (valid),
        .udp_send_data_ready (ready),
        .udp_send_data       (data),
        .udp_send_data_length(length),
        .pkt_seq             (pkt_seq),
        .drop_cnt            (drop_cnt)
    );

    always #10 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // A byte presented with ready high at the falling edge is consumed at the next rising edge.
    always @(negedge clk) begin
        if (rst_n && valid && ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected byte: got %0h, expected none", data);
            end else begin
                checkOutput("stream byte", 32'(data), 32'(exp_q.pop_front()));
                checkOutput("length", 32'(length), 32'(LEN));
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic applyStimulus(input logic [CH-1:0] mask, input logic [15:0] d0, input logic [15:0] d1);
        smp_valid = mask;
        smp_data  = {d1, d0};
        idle(1);
        smp_valid = '0;
        smp_data  = 32'hDEADBEEF;
    endtask

    task automatic pushFrame(input logic [15:0] d0, input logic [15:0] d1);
        exp_q.push_back(d0[15:8]);
        exp_q.push_back(d0[7:0]);
        exp_q.push_back(d1[15:8]);
        exp_q.push_back(d1[7:0]);
    endtask

    task automatic pushHeader();
        logic [15:0] seq;
        blk_cnt++;
        seq = 16'(blk_cnt);
        if (HDR) begin
            exp_q.push_back(seq[15:8]);
            exp_q.push_back(seq[7:0]);
            exp_q.push_back(8'(CH));
            exp_q.push_back(8'(SW));
        end
    endtask

    task automatic sendBlock(input logic [15:0] b0, input logic [15:0] b1);
        pushHeader();
        for (int n = 0; n < FRAMES; n++) begin
            pushFrame(b0 + 16'(n), b1 + 16'(n));
        end
        for (int n = 0; n < FRAMES; n++) begin
            applyStimulus(2'b11, b0 + 16'(n), b1 + 16'(n));
            idle(4);
        end
    endtask

    task automatic waitDrain(input bit toggle, input string name);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || valid) && n < 3000) begin
            idle(1);
            if (toggle) ready = ~ready;
            n++;
        end
        checkOutput({name, " drained in time"}, 32'(n < 3000), 32'd1);
        ready = 1'b1;
        idle(2);
    endtask

    initial begin
        int n;
        $display("[TB] start, header %0d, packet length %0d", HDR, LEN);
        rst_n = 1'b0;
        idle(3);
        rst_n = 1'b1;
        checkOutput("reset valid", 32'(valid), 32'd0);
        checkOutput("reset data", 32'(data), 32'd0);
        checkOutput("reset length", 32'(length), 32'd0);
        checkOutput("reset pkt_seq", 32'(pkt_seq), 32'd0);
        checkOutput("reset drop_cnt", 32'(drop_cnt), 32'd0);

        ready = 1'b1;
        sendBlock(16'h1000, 16'h2000);
        waitDrain(1'b0, "basic packet");
        checkOutput("pkt_seq after first", 32'(pkt_seq), 32'd1);
        checkOutput("valid idle after first", 32'(valid), 32'd0);

        sendBlock(16'h1000, 16'h2000);
        waitDrain(1'b0, "second packet");
        checkOutput("pkt_seq after second", 32'(pkt_seq), 32'd2);

        sendBlock(16'h3000, 16'h4000);
        waitDrain(1'b1, "toggled ready");
        checkOutput("pkt_seq after toggle", 32'(pkt_seq), 32'd3);

        ready = 1'b0;
        sendBlock(16'h5000, 16'h6000);
        sendBlock(16'h7000, 16'h8000);
        for (int k = 0; k < 3; k++) begin
            applyStimulus(2'b11, 16'h5500 + 16'(k), 16'h6600 + 16'(k));
            idle(4);
        end
        idle(4);
        checkOutput("drop_cnt both full", 32'(drop_cnt), 32'd3);
        checkOutput("valid held while stalled", 32'(valid), 32'd1);
        checkOutput("data held while stalled", 32'(data), 32'(exp_q[0]));
        checkOutput("length while stalled", 32'(length), 32'(LEN));
        ready = 1'b1;
        waitDrain(1'b0, "two queued packets");
        checkOutput("pkt_seq after backlog", 32'(pkt_seq), 32'd5);
        checkOutput("drop_cnt kept", 32'(drop_cnt), 32'd3);

        pushHeader();
        for (int f = 0; f < FRAMES; f++) begin
            pushFrame(16'h9000 + 16'(f), 16'hA000 + 16'(f));
        end
        applyStimulus(2'b01, 16'h1111, 16'hBAD0);
        idle(1);
        applyStimulus(2'b01, 16'h9000, 16'hBAD1);
        idle(2);
        applyStimulus(2'b10, 16'hBAD2, 16'hA000);
        idle(4);
        for (int f = 1; f < FRAMES; f++) begin
            applyStimulus(2'b11, 16'h9000 + 16'(f), 16'hA000 + 16'(f));
            idle(4);
        end
        waitDrain(1'b0, "skewed frame");
        checkOutput("drop_cnt after skew", 32'(drop_cnt), 32'd3);
        checkOutput("pkt_seq after skew", 32'(pkt_seq), 32'd6);

        sendBlock(16'hB000, 16'hC000);
        n = 0;
        while (exp_q.size() > 8 && n < 500) begin
            idle(1);
            n++;
        end
        checkOutput("mid-payload reached", 32'(n < 500), 32'd1);
        rst_n = 1'b0;
        exp_q.delete();
        blk_cnt = 0;
        idle(1);
        rst_n = 1'b1;
        checkOutput("valid after reset", 32'(valid), 32'd0);
        checkOutput("pkt_seq after reset", 32'(pkt_seq), 32'd0);
        checkOutput("drop_cnt after reset", 32'(drop_cnt), 32'd0);
        idle(2);
        sendBlock(16'hD000, 16'hE000);
        waitDrain(1'b0, "post-reset packet");
        checkOutput("pkt_seq post-reset", 32'(pkt_seq), 32'd1);
        checkOutput("scoreboard empty", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
